// File: rtl/avalon_slave_mem.sv
// Avalon-MM responder memory: wait-state handshake, back-door preload, sticky protocol_err.
// Optional macro AVS_STALL_RANDOM_EN replaces the fixed stall with an LFSR-derived one.
module avalon_slave_mem #(
   parameter int          ADDR_W      = 8,
   parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic [3:0]        byteenable,
   output logic              waitrequest,
   output logic [31:0]       readdata,
   input  logic              load_en,
   input  logic [ADDR_W+1:0] load_addr,
   input  logic [31:0]       load_data,
   output logic              protocol_err
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2} state_t;

   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0] mem_r [DEPTH];
   state_t      state_r, state_s;
   logic [7:0]  cnt_r, cnt_s;
   logic [31:0] addr_r, addr_s;
   logic [31:0] wdata_r, wdata_s;
   logic [3:0]  be_r, be_s;
   logic        op_wr_r, op_wr_s;
   logic [31:0] readdata_r, readdata_s;
   logic        perr_r, perr_s;
   logic [7:0]  stall_s;
   logic        accept_s;
   logic        hold_ok_s;
   logic        commit_s;
   logic        unused_s;

   function automatic logic in_window(input logic [31:0] a);
      return ((a - BASE_ADDR) >> (ADDR_W + 2)) == 32'd0;
   endfunction

   function automatic logic [ADDR_W-1:0] word_of(input logic [31:0] a);
      return ADDR_W'((a - BASE_ADDR) >> 2);
   endfunction

`ifdef AVS_STALL_RANDOM_EN
   logic [7:0] lfsr_r;

   // Stall LFSR (x^8+x^6+x^5+x^4+1), stepped once per accepted request
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_r <= 8'hA5;
      end else if (accept_s) begin
         lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
      end else begin
         lfsr_r <= lfsr_r;
      end
   end

   assign stall_s = 8'({1'b0, lfsr_r} % 9'(WAIT_CYCLES + 1));
`else
   assign stall_s = 8'(WAIT_CYCLES);
`endif

   // Next-state, capture, handshake and error logic
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      addr_s      = addr_r;
      wdata_s     = wdata_r;
      be_s        = be_r;
      op_wr_s     = op_wr_r;
      readdata_s  = readdata_r;
      perr_s      = perr_r;
      accept_s    = 1'b0;
      waitrequest = 1'b0;
      // The master must hold the exact captured request for the whole stall
      hold_ok_s   = (read ^ write) && (write == op_wr_r) && (address == addr_r) &&
                    (writedata == wdata_r) && (byteenable == be_r);
      case (state_r)
         IDLE: begin
            waitrequest = read | write;
            if (read && write) begin
               perr_s = 1'b1;
            end else if (read || write) begin
               accept_s = 1'b1;
               addr_s   = address;
               wdata_s  = writedata;
               be_s     = byteenable;
               op_wr_s  = write;
               cnt_s    = stall_s;
               if (stall_s != 8'd0) begin
                  state_s = BUSY;
               end else begin
                  state_s = ACK;
               end
            end else begin
               state_s = IDLE;
            end
         end
         BUSY: begin
            waitrequest = 1'b1;
            if (!hold_ok_s) begin
               perr_s  = 1'b1;
               cnt_s   = 8'd0;
               state_s = IDLE;
            end else if (cnt_r == 8'd1) begin
               cnt_s   = 8'd0;
               state_s = ACK;
            end else begin
               cnt_s   = cnt_r - 8'd1;
               state_s = BUSY;
            end
         end
         ACK: begin
            waitrequest = 1'b0;
            state_s     = IDLE;
         end
         default: begin
            waitrequest = 1'b0;
            state_s     = IDLE;
         end
      endcase
      // readdata is loaded on entry to ACK so it is valid during the ACK cycle
      if (state_s == ACK && !op_wr_s) begin
         readdata_s = in_window(addr_s) ? mem_r[word_of(addr_s)] : 32'h0000_0000;
      end else begin
         readdata_s = readdata_r;
      end
   end

   // Control state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         cnt_r      <= 8'd0;
         addr_r     <= 32'd0;
         wdata_r    <= 32'd0;
         be_r       <= 4'd0;
         op_wr_r    <= 1'b0;
         readdata_r <= 32'd0;
         perr_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         addr_r     <= addr_s;
         wdata_r    <= wdata_s;
         be_r       <= be_s;
         op_wr_r    <= op_wr_s;
         readdata_r <= readdata_s;
         perr_r     <= perr_s;
      end
   end

   assign commit_s = (state_r == ACK) && op_wr_r && in_window(addr_r) && !reset;

   // Memory array: bus write at end of ACK, then preload (preload wins on the same word)
   always_ff @(posedge clk) begin
      if (commit_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_r[i]) begin
               mem_r[word_of(addr_r)][8*i +: 8] <= wdata_r[8*i +: 8];
            end
         end
      end
      if (load_en) begin
         mem_r[load_addr[ADDR_W+1:2]] <= load_data;
      end
   end

   assign readdata     = readdata_r;
   assign protocol_err = perr_r;
   assign unused_s     = ^{load_addr[1:0], accept_s};

endmodule

// File: tb/tb_avalon_slave_mem.sv
// Self-checking bench for avalon_slave_mem: directed table, protocol corner sequences,
// and randomized transfers against a word-array reference model.
module tb_avalon_slave_mem;
   localparam int          ADDR_W      = 8;
   localparam logic [31:0] BASE        = 32'hBFC00000;
   localparam int          WAIT_CYCLES = 2;

   logic              clk = 1'b0;
   logic              reset, read, write, load_en;
   logic              waitrequest, protocol_err;
   logic [31:0]       address, writedata, readdata, load_data;
   logic [3:0]        byteenable;
   logic [ADDR_W+1:0] load_addr;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] ref_mem [256];
   logic [31:0] last_rd;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [10];

   avalon_slave_mem #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
      .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
      .readdata(readdata), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      if (off >= 32'd1024) return 32'h0;
      return ref_mem[off / 32'd4];
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] off, w;
      off = a - BASE;
      if (off < 32'd1024) begin
         w = ref_mem[off / 32'd4];
         for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
         ref_mem[off / 32'd4] = w;
      end
   endtask

   // Called just after a rising edge with the DUT idle; returns readdata seen in the ACK cycle
   task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rd, output int waits);
      read = !wr; write = wr; address = a; writedata = d; byteenable = be;
      waits = 0;
      @(negedge clk);
      while (waitrequest === 1'b1 && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      rd = readdata;
      @(posedge clk); #1;
      read = 1'b0; write = 1'b0;
   endtask

   task automatic run_xfer(input string name, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be, output logic [31:0] rd);
      logic [31:0] exp;
      int          waits;
      exp = wr ? last_rd : model_read(a);
      xfer(wr, a, d, be, rd, waits);
      check({name, " waits"}, 32'(waits), 32'(WAIT_CYCLES + 1));
      check({name, " rdata"}, rd, exp);
      if (wr) model_write(a, d, be);
      else last_rd = exp;
   endtask

   task automatic preload(input int w, input logic [31:0] d);
      load_en = 1'b1; load_addr = 10'(w * 4); load_data = d;
      @(posedge clk); #1;
      load_en = 1'b0;
      ref_mem[w] = d;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      last_rd = 32'h0;
   endtask

   initial begin
      logic [31:0] rd;
      int          cnt;
      reset = 1'b1; read = 1'b0; write = 1'b0; address = 32'h0; writedata = 32'h0;
      byteenable = 4'h0; load_en = 1'b0; load_addr = '0; load_data = 32'h0;
      last_rd = 32'h0;

      // Reset state, and waitrequest follows the IDLE rule while in reset
      @(posedge clk); #1;
      check("rst readdata", readdata, 32'h0);
      check("rst perr", {31'd0, protocol_err}, 32'd0);
      check("rst wait noreq", {31'd0, waitrequest}, 32'd0);
      read = 1'b1; #1;
      check("rst wait req", {31'd0, waitrequest}, 32'd1);
      read = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < 256; i++) preload(i, $urandom);
      preload(0, 32'hA5A5A5A5);
      preload(1, 32'h2403F00F);
      preload(2, 32'hC0DEC0DE);
      preload(5, 32'h11223344);
      preload(8, 32'h0BADF00D);
      preload(9, 32'h5A5A5A5A);
      preload(255, 32'h00000000);

      run_xfer("plan1 read", 1'b0, 32'hBFC00004, 32'h0, 4'hF, rd);
      check("plan1 const", rd, 32'h2403F00F);

      vecs[0] = '{1'b1, 32'hBFC00010, 32'hDEADBEEF, 4'b1111, 32'h0};
      vecs[1] = '{1'b1, 32'hBFC00010, 32'h00000000, 4'b0010, 32'h0};
      vecs[2] = '{1'b0, 32'hBFC00010, 32'h0,        4'b1111, 32'hDEAD00EF};
      vecs[3] = '{1'b0, 32'h00000000, 32'h0,        4'b1111, 32'h00000000};
      vecs[4] = '{1'b1, 32'hBFC00014, 32'hCAFEF00D, 4'b0000, 32'h0};
      vecs[5] = '{1'b0, 32'hBFC00014, 32'h0,        4'b1111, 32'h11223344};
      vecs[6] = '{1'b1, 32'hBFC00400, 32'hFFFFFFFF, 4'b1111, 32'h0};
      vecs[7] = '{1'b0, 32'hBFC00000, 32'h0,        4'b1111, 32'hA5A5A5A5};
      vecs[8] = '{1'b0, 32'hBFC00013, 32'h0,        4'b1111, 32'hDEAD00EF};
      vecs[9] = '{1'b1, 32'hBFC003FC, 32'h87654321, 4'b1001, 32'h0};
      for (int i = 0; i < 10; i++) begin
         run_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd);
         if (!vecs[i].wr) check($sformatf("vec%0d const", i), rd, vecs[i].exp_rd);
      end
      run_xfer("last word", 1'b0, 32'hBFC003FC, 32'h0, 4'hF, rd);
      check("last word const", rd, 32'h87000021);
      check("table perr", {31'd0, protocol_err}, 32'd0);

      // read and write together: never accepted, flag sticks until reset
      read = 1'b1; write = 1'b1; address = 32'hBFC00000; writedata = 32'hFFFFFFFF; byteenable = 4'hF;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("both wait c%0d", k), {31'd0, waitrequest}, 32'd1);
         check($sformatf("both perr c%0d", k), {31'd0, protocol_err}, (k > 0) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
      end
      read = 1'b0; write = 1'b0;
      run_xfer("both unchanged", 1'b0, 32'hBFC00000, 32'h0, 4'hF, rd);
      check("both sticky", {31'd0, protocol_err}, 32'd1);
      pulse_reset();
      check("both cleared", {31'd0, protocol_err}, 32'd0);

      // write dropped in the last BUSY cycle aborts without commit
      read = 1'b0; write = 1'b1; address = 32'hBFC00020; writedata = 32'h12345678; byteenable = 4'hF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      write = 1'b0;
      @(posedge clk); #1;
      check("drop perr", {31'd0, protocol_err}, 32'd1);
      run_xfer("drop readback", 1'b0, 32'hBFC00020, 32'h0, 4'hF, rd);
      pulse_reset();

      // address change in BUSY: abort, then the held request is accepted afresh
      read = 1'b1; address = 32'hBFC00004; byteenable = 4'hF; writedata = 32'h0;
      @(posedge clk); #1;
      address = 32'hBFC00008;
      cnt = 0;
      @(negedge clk);
      while (waitrequest === 1'b1 && cnt < 50) begin
         cnt++;
         @(negedge clk);
      end
      check("addrchg waits", 32'(cnt), 32'd4);
      check("addrchg rdata", readdata, 32'hC0DEC0DE);
      check("addrchg perr", {31'd0, protocol_err}, 32'd1);
      @(posedge clk); #1;
      read = 1'b0;
      last_rd = 32'hC0DEC0DE;

      // preload and ACK write hit the same word on the same edge
      write = 1'b1; address = 32'hBFC00028; writedata = 32'hFFFFFFFF; byteenable = 4'hF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("coll ack", {31'd0, waitrequest}, 32'd0);
      load_en = 1'b1; load_addr = 10'h028; load_data = 32'h13579BDF;
      @(posedge clk); #1;
      load_en = 1'b0; write = 1'b0;
      ref_mem[10] = 32'h13579BDF;
      run_xfer("coll read", 1'b0, 32'hBFC00028, 32'h0, 4'hF, rd);
      check("coll const", rd, 32'h13579BDF);

      // reset in BUSY of a write: dropped; preload on the reset edge still lands
      run_xfer("pre-rst read", 1'b0, 32'hBFC00004, 32'h0, 4'hF, rd);
      write = 1'b1; address = 32'hBFC00024; writedata = 32'hFFFFFFFF; byteenable = 4'hF;
      @(posedge clk); #1;
      reset = 1'b1; write = 1'b0;
      load_en = 1'b1; load_addr = 10'h028; load_data = 32'h77778888;
      @(posedge clk); #1;
      reset = 1'b0; load_en = 1'b0;
      ref_mem[10] = 32'h77778888;
      last_rd = 32'h0;
      check("rstbusy wait", {31'd0, waitrequest}, 32'd0);
      check("rstbusy rdata", readdata, 32'h0);
      check("rstbusy perr", {31'd0, protocol_err}, 32'd0);
      run_xfer("rstbusy nowrite", 1'b0, 32'hBFC00024, 32'h0, 4'hF, rd);
      check("rstbusy const", rd, 32'h5A5A5A5A);
      run_xfer("rstbusy preload", 1'b0, 32'hBFC00028, 32'h0, 4'hF, rd);
      run_xfer("retained", 1'b0, 32'hBFC00004, 32'h0, 4'hF, rd);

      // Randomized legal traffic against the reference model
      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         if ($urandom_range(0, 9) == 0) a = $urandom;
         else a = BASE + 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 7) == 0) preload($urandom_range(0, 255), $urandom);
         run_xfer($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom,
                  4'($urandom_range(0, 15)), rd);
      end
      check("final perr", {31'd0, protocol_err}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
